rot_win_gen: RTL and testbench

//  Parametrised circular line-buffer index manager; successor to the fixed 4-slot/3-tap rotating counter.

---
 rtl/rot_pkg.sv | 9 +
 rtl/rot_idx_add.sv | 13 +
 rtl/rot_win_gen.sv | 68 ++++++
 tb/tb_rot_win_gen.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// rot_pkg: shared operation encoding and compare-and-subtract modular add for rot_win_gen
package rot_pkg;
  typedef enum logic [1:0] {NOP, PUSH, POP, BOTH} op_t;
  function automatic int unsigned mod_add(input int unsigned a, input int unsigned b, input int unsigned depth);
    int unsigned s;
    s = a + b;
    return s >= depth ? s - depth : s;
  endfunction
endpackage

// File: rtl/rot_idx_add.sv
// rot_idx_add: combinational index adder wrapping at DEPTH, operands < DEPTH
module rot_idx_add
  import rot_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] y
);
  assign y = AW'(mod_add(32'(a), 32'(b), DEPTH));
endmodule

// File: rtl/rot_win_gen.sv
// rot_win_gen: circular line-buffer base/fill tracker emitting window and write indices; ROT_WIN_REVERSE_EN adds rev for newest-first cd
module rot_win_gen
  import rot_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAPS = 3,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
`ifdef ROT_WIN_REVERSE_EN
  input  logic              rev,
`endif
  output logic [AW-1:0]     wr_idx,
  output logic [TAPS*AW-1:0] cd,
  output logic [AW:0]       fill,
  output logic              win_valid,
  output logic              full,
  output logic              ovf,
  output logic              unf
);
  logic [AW-1:0] base;
  logic [AW-1:0] base_inc;
  op_t op;
  assign op = op_t'({pop, push});
  assign base_inc = AW'(mod_add(32'(base), 1, DEPTH));
  assign win_valid = fill >= (AW+1)'(TAPS);
  assign full = fill == (AW+1)'(DEPTH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      base <= '0;
      fill <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (clr) begin
      base <= '0;
      fill <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else
      case (op)
        PUSH: if (full) ovf <= 1'b1; else fill <= fill + 1'b1;
        POP: if (fill == '0) unf <= 1'b1; else begin
          base <= base_inc;
          fill <= fill - 1'b1;
        end
        // an empty buffer cannot retire, so the push still lands
        BOTH: if (fill == '0) begin
          fill <= (AW+1)'(1);
          unf <= 1'b1;
        end else base <= base_inc;
        default: ;
      endcase
  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    logic [AW-1:0] off;
`ifdef ROT_WIN_REVERSE_EN
    assign off = rev ? AW'(TAPS - 1 - i) : AW'(i);
`else
    assign off = AW'(i);
`endif
    rot_idx_add #(.DEPTH(DEPTH)) u_add (.a(base), .b(off), .y(cd[i*AW +: AW]));
  end
  // a full buffer wraps the write slot back onto base
  rot_idx_add #(.DEPTH(DEPTH)) u_wr (.a(base), .b(full ? '0 : fill[AW-1:0]), .y(wr_idx));
endmodule

// File: tb/tb_rot_win_gen.sv
// tb_rot_win_gen: randomized and directed check of rot_win_gen (DEPTH 4 and 5, TAPS 3) against a modulo-arithmetic model
module tb_rot_win_gen;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, push = 1'b0, pop = 1'b0, rev = 1'b0;
  logic [1:0] wr4;
  logic [5:0] cd4;
  logic [2:0] fl4;
  logic wv4, fu4, ov4, un4;
  logic [2:0] wr5;
  logic [8:0] cd5;
  logic [3:0] fl5;
  logic wv5, fu5, ov5, un5;
  int vectors = 0, miscompares = 0;
  int dep[2] = '{4, 5};
  int mb[2], mf[2], mo[2], mu[2];
  always #5 clk = ~clk;

  rot_win_gen #(.DEPTH(4), .TAPS(3)) d4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .pop(pop),
`ifdef ROT_WIN_REVERSE_EN
    .rev(rev),
`endif
    .wr_idx(wr4), .cd(cd4), .fill(fl4), .win_valid(wv4), .full(fu4), .ovf(ov4), .unf(un4));
  rot_win_gen #(.DEPTH(5), .TAPS(3)) d5 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .pop(pop),
`ifdef ROT_WIN_REVERSE_EN
    .rev(rev),
`endif
    .wr_idx(wr5), .cd(cd5), .fill(fl5), .win_valid(wv5), .full(fu5), .ovf(ov5), .unf(un5));

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mb[k] = 0; mf[k] = 0; mo[k] = 0; mu[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        mb[k] = 0; mf[k] = 0; mo[k] = 0; mu[k] = 0;
      end else if (push && !pop) begin
        if (mf[k] == dep[k]) mo[k] = 1; else mf[k]++;
      end else if (pop && !push) begin
        if (mf[k] == 0) mu[k] = 1;
        else begin mb[k] = (mb[k] + 1) % dep[k]; mf[k]--; end
      end else if (push && pop) begin
        if (mf[k] == 0) begin mf[k] = 1; mu[k] = 1; end
        else mb[k] = (mb[k] + 1) % dep[k];
      end
    end
  endtask

  task automatic check_dut(input int k, input int wr, input int cdv, input int fl, input int wv, input int fu,
                           input int ov, input int un);
    int aw, d, slot;
    string p;
    d = dep[k];
    aw = (k == 0) ? 2 : 3;
    p = (k == 0) ? "d4" : "d5";
    for (int i = 0; i < 3; i++) begin
      slot = rev ? 2 - i : i;
`ifndef ROT_WIN_REVERSE_EN
      slot = i;
`endif
      check($sformatf("%s.cd[%0d]", p, i), (cdv >> (i * aw)) & ((1 << aw) - 1), (mb[k] + slot) % d);
    end
    check({p, ".wr_idx"}, wr, (mb[k] + mf[k]) % d);
    check({p, ".fill"}, fl, mf[k]);
    check({p, ".win_valid"}, wv, int'(mf[k] >= 3));
    check({p, ".full"}, fu, int'(mf[k] == d));
    check({p, ".ovf"}, ov, mo[k]);
    check({p, ".unf"}, un, mu[k]);
  endtask

  task automatic check_all();
    check_dut(0, int'(wr4), int'(cd4), int'(fl4), int'(wv4), int'(fu4), int'(ov4), int'(un4));
    check_dut(1, int'(wr5), int'(cd5), int'(fl5), int'(wv5), int'(fu5), int'(ov5), int'(un5));
  endtask

  task automatic step(input logic pu, input logic po, input logic cl);
    push = pu; pop = po; clr = cl;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  initial begin
    model_reset();
    #2 check_all();
    rst_n = 1'b1;
    repeat (3) step(1, 0, 0);
    check("d4.cd_packed", int'(cd4), (2 << 4) | (1 << 2));
    repeat (2) step(1, 0, 0);
    repeat (4) step(1, 1, 0);
    check("d5.cd_packed", int'(cd5), (1 << 6) | (0 << 3) | 4);
    step(1, 0, 0);
    check("d4.ovf_full", int'(ov4), 1);
    step(0, 0, 1);
    step(0, 1, 0);
    step(1, 1, 0);
    check("d4.unf_both", int'(un4), 1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("d4.pre_rst_base", int'(cd4[1:0]), 2);
    rst_n = 1'b0;
    model_reset();
    #1 check_all();
    check("d4.async_cd", int'(cd4), (2 << 4) | (1 << 2));
    rst_n = 1'b1;
`ifdef ROT_WIN_REVERSE_EN
    repeat (4) step(1, 0, 0);
    repeat (3) step(0, 1, 0);
    rev = 1'b1;
    #1 check_all();
    check("d4.rev_cd", int'(cd4), (3 << 4) | (0 << 2) | 1);
    rev = 1'b0;
    #1 check_all();
    check("d4.fwd_cd", int'(cd4), (1 << 4) | (0 << 2) | 3);
`endif
    for (int n = 0; n < 400; n++) begin
      rev = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 2) != 0 ? $urandom_range(0, 1) : 1),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 31) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
